// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter definitions: default widths, watchdog limit and FSM encoding.
package wb_pkg;

  localparam int unsigned ADR_W_DEF   = 8;
  localparam int unsigned DAT_W_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned WD_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// 8-bit transfer watchdog: counts while enabled, clears on request, flags the last allowed cycle.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with per-transfer watchdog in front of one slave.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned ADR_W   = ADR_W_DEF,
  parameter int unsigned DAT_W   = DAT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [ADR_W-1:0] M0_ADR_I,
  input  logic [ADR_W-1:0] M1_ADR_I,
  input  logic [DAT_W-1:0] M0_DAT_I,
  input  logic [DAT_W-1:0] M1_DAT_I,
  input  logic             M0_WE_I,
  input  logic             M1_WE_I,
  input  logic             M0_STB_I,
  input  logic             M1_STB_I,
  input  logic             M0_CYC_I,
  input  logic             M1_CYC_I,
  output logic [DAT_W-1:0] M0_DAT_O,
  output logic [DAT_W-1:0] M1_DAT_O,
  output logic             M0_ACK_O,
  output logic             M1_ACK_O,
  output logic             M0_ERR_O,
  output logic             M1_ERR_O,
  output logic [ADR_W-1:0] S_ADR_O,
  output logic [DAT_W-1:0] S_DAT_O,
  output logic             S_WE_O,
  output logic             S_STB_O,
  output logic             S_CYC_O,
  input  logic [DAT_W-1:0] S_DAT_I,
  input  logic             S_ACK_I
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       err_pulse_q, err_pulse_d;

  logic [ADR_W-1:0] o_adr;
  logic [DAT_W-1:0] o_dat;
  logic             o_we, o_stb, o_cyc;
  logic             busy, fwd_ack, wd_en, wd_exp;

  assign o_adr = owner_q ? M1_ADR_I : M0_ADR_I;
  assign o_dat = owner_q ? M1_DAT_I : M0_DAT_I;
  assign o_we  = owner_q ? M1_WE_I  : M0_WE_I;
  assign o_stb = owner_q ? M1_STB_I : M0_STB_I;
  assign o_cyc = owner_q ? M1_CYC_I : M0_CYC_I;
  assign busy  = (state_q == ST_BUSY);

  // Counting only while a strobe waits unacknowledged; any other cycle (incl. IDLE) clears it.
  assign wd_en = busy & o_cyc & o_stb & ~S_ACK_I;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (CLK_I),
    .rst     (RST_I),
    .clr     (~wd_en),
    .en      (wd_en),
    .expired (wd_exp)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    err_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (M0_CYC_I | M1_CYC_I) begin
          owner_d = (M0_CYC_I & M1_CYC_I) ? ~last_q : M1_CYC_I;
          last_d  = owner_d;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!o_cyc) begin
          state_d = ST_IDLE;
        end else if (o_stb && !S_ACK_I && wd_exp) begin
          state_d     = ST_ERR;
          err_pulse_d = 1'b1;
        end
      end
      ST_ERR: begin
        if (!o_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // An ACK arriving while reset is sampled belongs to an aborted transfer.
  assign fwd_ack = busy & o_cyc & S_ACK_I & ~RST_I;

  always_comb begin
    S_ADR_O  = '0;
    S_DAT_O  = '0;
    S_WE_O   = 1'b0;
    S_STB_O  = 1'b0;
    S_CYC_O  = 1'b0;
    M0_DAT_O = '0;
    M1_DAT_O = '0;
    if (busy) begin
      S_ADR_O = o_adr;
      S_DAT_O = o_dat;
      S_WE_O  = o_we;
      S_CYC_O = o_cyc;
      S_STB_O = o_cyc & o_stb;
      if (owner_q) M1_DAT_O = S_DAT_I;
      else         M0_DAT_O = S_DAT_I;
    end
  end

  assign M0_ACK_O = fwd_ack & ~owner_q;
  assign M1_ACK_O = fwd_ack & owner_q;
  assign M0_ERR_O = err_pulse_q & ~owner_q;
  assign M1_ERR_O = err_pulse_q & owner_q;

endmodule
